// File: rtl/add_sub_pkg.sv
// Shared constants for the block-floating-point add/sub datapath and its arbiter.
// Format: [15:13] unsigned scale, [12:0] two's-complement mantissa.
package add_sub_pkg;

   localparam int unsigned BFP_W     = 16;
   localparam int unsigned SCALE_MSB = 15;
   localparam int unsigned SCALE_LSB = 13;
   localparam int unsigned MANT_W    = 13;
   localparam int unsigned SCALE_W   = SCALE_MSB - SCALE_LSB + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = IDLE,
      StCalc = CALC,
      StDone = DONE
   } state_e;

endpackage

// File: rtl/add_sub_cla.sv
// BFP add/subtract: aligns the smaller-scale mantissa up to the larger scale, then
// adds with a parallel-prefix carry network. inv flags mantissa overflow or misalignment.
module add_sub_cla
   import add_sub_pkg::*;
(
   input  logic [BFP_W-1:0] a,
   input  logic [BFP_W-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic [BFP_W-1:0] out,
   output logic             inv,
   output logic             cout
);

   localparam int unsigned EXT_W = MANT_W + (1 << SCALE_W) - 1;

   logic [SCALE_W-1:0] sa, sb, sc, shamt;
   logic [MANT_W-1:0]  ma, mb, small_m, ma_al, mb_al, mb_eff, gk, pk, sum;
   logic [EXT_W-1:0]   small_ext;
   logic [MANT_W:0]    carry;
   logic               b_small, misalign, ovf;

   always_comb begin
      sa      = a[SCALE_MSB:SCALE_LSB];
      sb      = b[SCALE_MSB:SCALE_LSB];
      ma      = a[MANT_W-1:0];
      mb      = b[MANT_W-1:0];
      b_small = (sa >= sb);
      sc      = b_small ? sa : sb;
      shamt   = b_small ? (sa - sb) : (sb - sa);
      small_m = b_small ? mb : ma;

      // Larger scale means finer LSB, so the other mantissa is shifted up to match.
      small_ext = {{(EXT_W - MANT_W){small_m[MANT_W-1]}}, small_m} << shamt;
      misalign  = small_ext[EXT_W-1:MANT_W-1] !=
                  {(EXT_W - MANT_W + 1){small_ext[MANT_W-1]}};

      ma_al  = b_small ? ma : small_ext[MANT_W-1:0];
      mb_al  = b_small ? small_ext[MANT_W-1:0] : mb;
      mb_eff = sub ? ~mb_al : mb_al;

      gk = ma_al & mb_eff;
      pk = ma_al ^ mb_eff;
      // Kogge-Stone prefix; descending i keeps lower entries at the previous level.
      for (int s = 1; s < int'(MANT_W); s = s * 2) begin
         for (int i = int'(MANT_W) - 1; i >= s; i--) begin
            gk[i] = gk[i] | (pk[i] & gk[i-s]);
            pk[i] = pk[i] & pk[i-s];
         end
      end

      carry[0] = sub ^ cin;
      for (int i = 0; i < int'(MANT_W); i++) begin
         carry[i+1] = gk[i] | (pk[i] & carry[0]);
      end

      sum  = ma_al ^ mb_eff ^ carry[MANT_W-1:0];
      cout = carry[MANT_W];
      ovf  = (ma_al[MANT_W-1] == mb_eff[MANT_W-1]) && (sum[MANT_W-1] != ma_al[MANT_W-1]);
      inv  = ovf | misalign;
      out  = {sc, sum};
   end

endmodule

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Returns the winner as both a one-hot vector and a binary index.
module rr_arbiter_n #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [ID_W-1:0]  idx
);

   always_comb begin
      logic found;
      int   j;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         j = (int'(ptr) + k) % int'(N_REQ);
         if (!found && req[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            idx       = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/add_sub_arbiter.sv
// Shares one add_sub_cla among N_REQ requesters: grant, compute, return tagged result.
// One op every three cycles; saturating count of invalid results.
module add_sub_arbiter
   import add_sub_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2,
   parameter int unsigned ERR_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         req_sub,
   input  logic [BFP_W*N_REQ-1:0]   req_opa,
   input  logic [BFP_W*N_REQ-1:0]   req_opb,
   output logic [N_REQ-1:0]         gnt,
   output logic                     done,
   output logic [BFP_W-1:0]         res,
   output logic [ID_W-1:0]          res_id,
   output logic                     res_inv,
   output logic                     res_cout,
   output logic                     busy,
   output logic [ERR_W-1:0]         err_cnt
);

   state_e            state_q;
   logic [ID_W-1:0]   rr_ptr_q, id_q, res_id_q, win_idx;
   logic [BFP_W-1:0]  opa_q, opb_q, res_q, add_out;
   logic              sub_q, res_inv_q, res_cout_q, add_inv, add_cout;
   logic [ERR_W-1:0]  err_cnt_q;
   logic [N_REQ-1:0]  win_onehot;

   rr_arbiter_n #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req    (req),
      .ptr    (rr_ptr_q),
      .onehot (win_onehot),
      .idx    (win_idx)
   );

   add_sub_cla u_add (
      .a    (opa_q),
      .b    (opb_q),
      .sub  (sub_q),
      .cin  (1'b0),
      .out  (add_out),
      .inv  (add_inv),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         id_q       <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         sub_q      <= 1'b0;
         res_q      <= '0;
         res_id_q   <= '0;
         res_inv_q  <= 1'b0;
         res_cout_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (|req) begin
                  opa_q   <= req_opa[BFP_W*win_idx +: BFP_W];
                  opb_q   <= req_opb[BFP_W*win_idx +: BFP_W];
                  sub_q   <= req_sub[win_idx];
                  id_q    <= win_idx;
                  state_q <= StCalc;
               end
            end
            StCalc: begin
               res_q      <= add_out;
               res_inv_q  <= add_inv;
               res_cout_q <= add_cout;
               res_id_q   <= id_q;
               state_q    <= StDone;
            end
            StDone: begin
               if (res_inv_q && (err_cnt_q != '1)) begin
                  err_cnt_q <= err_cnt_q + 1'b1;
               end
               rr_ptr_q <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Grant is combinational so operands are sampled on the same edge that leaves IDLE.
   assign gnt      = (state_q == StIdle) ? win_onehot : '0;
   assign done     = (state_q == StDone);
   assign busy     = (state_q != StIdle);
   assign res      = res_q;
   assign res_id   = res_id_q;
   assign res_inv  = res_inv_q;
   assign res_cout = res_cout_q;
   assign err_cnt  = err_cnt_q;

endmodule
